// File: rtl/if_id_pipe.sv
// if_id_pipe: IF->ID pipeline register with valid/ready fetch handshake,
// decode stall, flush-to-bubble and a one-entry skid buffer.
// Optional performance counters are enabled by defining IF_ID_PERF_EN.
module if_id_pipe #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_F,
  output logic               ready_F,
  input  logic [ADDR_W-1:0]  PC_F,
  input  logic [ADDR_W-1:0]  PC_Plus4_F,
  input  logic [INSTR_W-1:0] Instr_F,
  input  logic               stall_D,
  input  logic               flush_D,
  output logic               valid_D,
  output logic [ADDR_W-1:0]  PC_D,
  output logic [ADDR_W-1:0]  PC_Plus4_D,
  output logic [INSTR_W-1:0] Instr_D,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0]  skid_pc4_q, skid_pc4_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               fetch_acc;
  logic               bubble_load;

  // ready_F comes straight from the skid flag, so stall/flush never reach it combinationally
  assign ready_F   = !skid_valid_q;
  assign fetch_acc = valid_F && !skid_valid_q;

  // Next-state for the D stage and skid buffer: flush > stall > advance
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    instr_d      = instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;
    bubble_load  = 1'b0;
    if (flush_D) begin
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      skid_valid_d = 1'b0;
      bubble_load  = 1'b1;
    end else if (stall_D) begin
      if (fetch_acc) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = PC_F;
        skid_pc4_d   = PC_Plus4_F;
        skid_instr_d = Instr_F;
      end
    end else if (skid_valid_q) begin
      valid_d      = 1'b1;
      pc_d         = skid_pc_q;
      pc4_d        = skid_pc4_q;
      instr_d      = skid_instr_q;
      skid_valid_d = 1'b0;
    end else if (fetch_acc) begin
      valid_d = 1'b1;
      pc_d    = PC_F;
      pc4_d   = PC_Plus4_F;
      instr_d = Instr_F;
    end else begin
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      bubble_load = 1'b1;
    end
  end

  // D-stage and skid registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      pc4_q        <= '0;
      instr_q      <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign valid_D    = valid_q;
  assign PC_D       = pc_q;
  assign PC_Plus4_D = pc4_q;
  assign Instr_D    = instr_q;

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating stall and bubble counters
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_D && valid_q && !flush_D && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bubble_load && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_load;
  assign stall_cnt     = '0;
  assign bubble_cnt    = '0;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe (honours IF_ID_PERF_EN).
module tb_if_id_pipe;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
`ifdef IF_ID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               valid_F;
  logic               ready_F;
  logic [ADDR_W-1:0]  PC_F;
  logic [ADDR_W-1:0]  PC_Plus4_F;
  logic [INSTR_W-1:0] Instr_F;
  logic               stall_D;
  logic               flush_D;
  logic               valid_D;
  logic [ADDR_W-1:0]  PC_D;
  logic [ADDR_W-1:0]  PC_Plus4_D;
  logic [INSTR_W-1:0] Instr_D;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   bubble_cnt;

  int n_cmp;
  int n_err;

  if_id_pipe #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_F(valid_F), .ready_F(ready_F),
    .PC_F(PC_F), .PC_Plus4_F(PC_Plus4_F), .Instr_F(Instr_F),
    .stall_D(stall_D), .flush_D(flush_D), .valid_D(valid_D),
    .PC_D(PC_D), .PC_Plus4_D(PC_Plus4_D), .Instr_D(Instr_D),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] ins);
    valid_F    = v;
    PC_F       = pc;
    PC_Plus4_F = pc + 32'd4;
    Instr_F    = ins;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_D = 1'b0; flush_D = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    step(); step();
    n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h want 0", valid_D); end
    n_cmp++; if (PC_D !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %0h want 0", PC_D); end
    n_cmp++; if (PC_Plus4_D !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %0h want 0", PC_Plus4_D); end
    n_cmp++; if (Instr_D !== NOP) begin n_err++; $display("FAIL reset_instr: got %0h want %0h", Instr_D, NOP); end
    n_cmp++; if (ready_F !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0h want 1", ready_F); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (bubble_cnt !== 4'd0) begin n_err++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    offer(1'b1, 32'h100, 32'h2008_0005);
    step();
    n_cmp++; if (valid_D !== 1'b1) begin n_err++; $display("FAIL fetch_valid: got %0h want 1", valid_D); end
    n_cmp++; if (PC_D !== 32'h100) begin n_err++; $display("FAIL fetch_pc: got %0h want 100", PC_D); end
    n_cmp++; if (PC_Plus4_D !== 32'h104) begin n_err++; $display("FAIL fetch_pc4: got %0h want 104", PC_Plus4_D); end
    n_cmp++; if (Instr_D !== 32'h2008_0005) begin n_err++; $display("FAIL fetch_instr: got %0h want 20080005", Instr_D); end
    n_cmp++; if (ready_F !== 1'b1) begin n_err++; $display("FAIL fetch_ready: got %0h want 1", ready_F); end
  endtask

  task automatic test_stall_skid();
    stall_D = 1'b1;
    offer(1'b1, 32'h104, 32'h1111_1111);
    for (int c = 0; c < 3; c++) begin
      step();
      offer(1'b0, 32'h0, 32'h0);
      n_cmp++; if (PC_D !== 32'h100) begin n_err++; $display("FAIL stall_hold_pc[%0d]: got %0h want 100", c, PC_D); end
      n_cmp++; if (Instr_D !== 32'h2008_0005) begin n_err++; $display("FAIL stall_hold_instr[%0d]: got %0h want 20080005", c, Instr_D); end
      n_cmp++; if (valid_D !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid[%0d]: got %0h want 1", c, valid_D); end
      n_cmp++; if (ready_F !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %0h want 0", c, ready_F); end
    end
    stall_D = 1'b0;
    step();
    n_cmp++; if (PC_D !== 32'h104) begin n_err++; $display("FAIL drain_pc: got %0h want 104", PC_D); end
    n_cmp++; if (PC_Plus4_D !== 32'h108) begin n_err++; $display("FAIL drain_pc4: got %0h want 108", PC_Plus4_D); end
    n_cmp++; if (Instr_D !== 32'h1111_1111) begin n_err++; $display("FAIL drain_instr: got %0h want 11111111", Instr_D); end
    n_cmp++; if (valid_D !== 1'b1) begin n_err++; $display("FAIL drain_valid: got %0h want 1", valid_D); end
    n_cmp++; if (ready_F !== 1'b1) begin n_err++; $display("FAIL drain_ready: got %0h want 1", ready_F); end
    n_cmp++; if (stall_cnt !== (PERF ? 4'd3 : 4'd0)) begin n_err++; $display("FAIL stall_cnt_3: got %0d want %0d", stall_cnt, PERF ? 3 : 0); end
  endtask

  task automatic test_flush();
    stall_D = 1'b1;
    offer(1'b1, 32'h180, 32'h2222_2222);
    step();
    n_cmp++; if (ready_F !== 1'b0) begin n_err++; $display("FAIL flush_pre_ready: got %0h want 0", ready_F); end
    flush_D = 1'b1;
    offer(1'b1, 32'h200, 32'h3333_3333);
    step();
    n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0h want 0", valid_D); end
    n_cmp++; if (Instr_D !== NOP) begin n_err++; $display("FAIL flush_instr: got %0h want %0h", Instr_D, NOP); end
    n_cmp++; if (ready_F !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %0h want 1", ready_F); end
    n_cmp++; if (stall_cnt !== (PERF ? 4'd4 : 4'd0)) begin n_err++; $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, PERF ? 4 : 0); end
    flush_D = 1'b0; stall_D = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    step();
    n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL post_flush_valid: got %0h want 0", valid_D); end
    n_cmp++; if (PC_D !== 32'h104) begin n_err++; $display("FAIL post_flush_pc: got %0h want 104", PC_D); end
    n_cmp++; if (Instr_D !== NOP) begin n_err++; $display("FAIL post_flush_instr: got %0h want %0h", Instr_D, NOP); end
    n_cmp++; if (bubble_cnt !== (PERF ? 4'd2 : 4'd0)) begin n_err++; $display("FAIL flush_bubble_cnt: got %0d want %0d", bubble_cnt, PERF ? 2 : 0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      step();
      n_cmp++; if (valid_D !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %0h want 1", i, valid_D); end
      n_cmp++; if (PC_D !== 32'h300 + 32'(4 * i)) begin n_err++; $display("FAIL b2b_pc[%0d]: got %0h want %0h", i, PC_D, 32'h300 + 32'(4 * i)); end
      n_cmp++; if (Instr_D !== 32'hA000_0000 + 32'(i)) begin n_err++; $display("FAIL b2b_instr[%0d]: got %0h want %0h", i, Instr_D, 32'hA000_0000 + 32'(i)); end
      n_cmp++; if (ready_F !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %0h want 1", i, ready_F); end
    end
    offer(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_bubble();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL bubble_valid: got %0h want 0", valid_D); end
    n_cmp++; if (Instr_D !== NOP) begin n_err++; $display("FAIL bubble_instr: got %0h want %0h", Instr_D, NOP); end
    n_cmp++; if (bubble_cnt !== (PERF ? 4'd2 : 4'd0)) begin n_err++; $display("FAIL bubble_cnt_2: got %0d want %0d", bubble_cnt, PERF ? 2 : 0); end
  endtask

  task automatic test_saturate_reset();
    offer(1'b1, 32'h400, 32'h4444_4444);
    step();
    stall_D = 1'b1;
    offer(1'b1, 32'h404, 32'h5555_5555);
    step();
    offer(1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 19; c++) step();
    n_cmp++; if (stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin n_err++; $display("FAIL stall_cnt_sat: got %0d want %0d", stall_cnt, PERF ? 15 : 0); end
    n_cmp++; if (PC_D !== 32'h400) begin n_err++; $display("FAIL sat_hold_pc: got %0h want 400", PC_D); end
    n_cmp++; if (ready_F !== 1'b0) begin n_err++; $display("FAIL sat_ready: got %0h want 0", ready_F); end
    rst = 1'b1;
    step();
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %0h want 0", valid_D); end
    n_cmp++; if (ready_F !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %0h want 1", ready_F); end
    rst = 1'b0; stall_D = 1'b0;
    step();
    n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL rst_skid_gone: got %0h want 0", valid_D); end
    n_cmp++; if (Instr_D !== NOP) begin n_err++; $display("FAIL rst_skid_instr: got %0h want %0h", Instr_D, NOP); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fetch();
    test_stall_skid();
    test_flush();
    test_back_to_back();
    test_bubble();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
